// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan driver: active-low glyph table,
// the dark code and the digit-index width helper.
package seg7_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Entry n is the active-low g..a pattern for hex digit n.
  localparam logic [15:0][6:0] GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h18, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low seven-segment glyph.
module seg7_hex_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg_L
);

  assign seg_L = GLYPH[nib];

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed common-anode display driver with tear-free frame updates,
// leading-zero blanking and a one-cycle anti-ghosting dead time per digit.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp,
  input  logic                    value_valid,
  input  logic                    blank,
  output logic [6:0]              seg_L,
  output logic                    dp_L,
  output logic [NUM_DIGITS-1:0]   an_L,
  output logic                    frame_done
);

  localparam int IW = idx_w(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);

  logic [PW-1:0]                  presc_q, presc_d;
  logic [IW-1:0]                  idx_q, idx_d;
  logic                           chg_q, chg_d;
  logic [NUM_DIGITS-1:0][3:0]     pend_q, pend_d, disp_q, disp_d, value_nib;
  logic [NUM_DIGITS-1:0]          pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
  logic                           pflag_q, pflag_d;
  logic [6:0]                     seg_q, seg_d;
  logic                           dpl_q, dpl_d, fd_q, fd_d;
  logic [NUM_DIGITS-1:0]          an_q, an_d;

  logic                           tc, frame_bnd, zero_run, sel_dp;
  logic [NUM_DIGITS-1:0]          lz_mask, sel_an;
  logic [NUM_DIGITS-1:0][6:0]     glyph;
  logic [6:0]                     sel_seg;

  assign value_nib = value;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_hex_decode u_dec (.nib(disp_q[g]), .seg_L(glyph[g]));
  end

  always_comb begin
    tc        = (presc_q == PW'(REFRESH_DIV - 1));
    frame_bnd = tc && (idx_q == IW'(NUM_DIGITS - 1));
    presc_d   = tc ? '0 : presc_q + 1'b1;
    idx_d     = idx_q;
    if (tc) idx_d = (idx_q == IW'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    // Registered so the outputs go dark on the first cycle of each new digit.
    chg_d     = tc;

    pend_d    = pend_q;
    pend_dp_d = pend_dp_q;
    pflag_d   = pflag_q;
    disp_d    = disp_q;
    disp_dp_d = disp_dp_q;
    if (frame_bnd) begin
      if (value_valid) begin
        disp_d    = value_nib;
        disp_dp_d = dp;
        pflag_d   = 1'b0;
      end else if (pflag_q) begin
        disp_d    = pend_q;
        disp_dp_d = pend_dp_q;
        pflag_d   = 1'b0;
      end
    end else if (value_valid) begin
      pend_d    = value_nib;
      pend_dp_d = dp;
      pflag_d   = 1'b1;
    end
  end

  // A digit is blanked when it and everything above it is zero; digit 0 always shows.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run   = zero_run && (disp_q[k] == 4'h0);
      lz_mask[k] = (LZ_BLANK != 0) && (k != 0) && zero_run;
    end
  end

  always_comb begin
    sel_seg = SEG_OFF;
    sel_dp  = 1'b0;
    sel_an  = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IW'(k)) begin
        sel_seg   = lz_mask[k] ? SEG_OFF : glyph[k];
        sel_dp    = disp_dp_q[k];
        sel_an[k] = 1'b0;
      end
    end
    an_d  = (blank || chg_q) ? '1 : sel_an;
    seg_d = blank ? SEG_OFF : sel_seg;
    dpl_d = blank ? 1'b1 : ~sel_dp;
    fd_d  = chg_q && (idx_q == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q   <= '0;
      idx_q     <= '0;
      chg_q     <= 1'b0;
      pend_q    <= '0;
      pend_dp_q <= '0;
      pflag_q   <= 1'b0;
      disp_q    <= '0;
      disp_dp_q <= '0;
      seg_q     <= SEG_OFF;
      dpl_q     <= 1'b1;
      an_q      <= '1;
      fd_q      <= 1'b0;
    end else begin
      presc_q   <= presc_d;
      idx_q     <= idx_d;
      chg_q     <= chg_d;
      pend_q    <= pend_d;
      pend_dp_q <= pend_dp_d;
      pflag_q   <= pflag_d;
      disp_q    <= disp_d;
      disp_dp_q <= disp_dp_d;
      seg_q     <= seg_d;
      dpl_q     <= dpl_d;
      an_q      <= an_d;
      fd_q      <= fd_d;
    end
  end

  assign seg_L      = seg_q;
  assign dp_L       = dpl_q;
  assign an_L       = an_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench: cycle-count display model checked every cycle on three configurations,
// plus literal expectations at the key scan points.
module tb_seg7_scan_driver;
  localparam int N   = 4;
  localparam int RD  = 4;
  localparam int RD1 = 3;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp = '0;
  logic        vv = 1'b0, blank = 1'b0;

  logic [6:0] seg_a, seg_b, seg_c;
  logic       dpl_a, dpl_b, dpl_c, fd_a, fd_b, fd_c;
  logic [3:0] an_a, an_b;
  logic [0:0] an_c;

  int checks = 0, fails = 0;

  always #5 clk = ~clk;

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .LZ_BLANK(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .value_valid(vv), .blank(blank),
    .seg_L(seg_a), .dp_L(dpl_a), .an_L(an_a), .frame_done(fd_a));

  seg7_scan_driver #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .LZ_BLANK(0)) u_dut_nl (
    .clk(clk), .rst_n(rst_n), .value(value), .dp(dp), .value_valid(vv), .blank(blank),
    .seg_L(seg_b), .dp_L(dpl_b), .an_L(an_b), .frame_done(fd_b));

  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(RD1), .LZ_BLANK(1)) u_dut_one (
    .clk(clk), .rst_n(rst_n), .value(4'h0), .dp(1'b0), .value_valid(1'b0), .blank(blank),
    .seg_L(seg_c), .dp_L(dpl_c), .an_L(an_c), .frame_done(fd_c));

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [6:0] gl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h18, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  int         s;
  logic [3:0] md [N];
  logic [3:0] mp [N];
  logic [3:0] mdp, mpdp;
  bit         mpf;
  int         m_pos, m_idx, m_ph, m_hnz;
  bit         m_dead, m_bnd, m_lzb, m_dead1;

  logic [3:0] e_an = 4'hF;
  logic [6:0] e_seg_lz = 7'h7F, e_seg_nl = 7'h7F, e_seg1 = 7'h7F;
  logic       e_dpl = 1'b1, e_fd = 1'b0, e_an1 = 1'b1, e_fd1 = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s = 0; mpf = 0; mdp = '0; mpdp = '0;
      for (int k = 0; k < N; k++) begin md[k] = '0; mp[k] = '0; end
      e_an = 4'hF; e_seg_lz = 7'h7F; e_seg_nl = 7'h7F; e_dpl = 1'b1; e_fd = 1'b0;
      e_an1 = 1'b1; e_seg1 = 7'h7F; e_fd1 = 1'b0;
    end else begin
      // s = edges since reset; outputs after this edge describe state s
      m_pos  = s % (N * RD);
      m_idx  = m_pos / RD;
      m_ph   = m_pos % RD;
      m_dead = (m_ph == 0) && (s > 0);
      m_hnz  = -1;
      for (int k = 0; k < N; k++) if (md[k] != 0) m_hnz = k;
      m_lzb  = (m_idx > 0) && (m_idx > m_hnz);
      e_an     = (blank || m_dead) ? 4'hF : ~(4'b0001 << m_idx);
      e_seg_nl = blank ? 7'h7F : gl[md[m_idx]];
      e_seg_lz = (blank || m_lzb) ? 7'h7F : gl[md[m_idx]];
      e_dpl    = blank ? 1'b1 : !mdp[m_idx];
      e_fd     = m_dead && (m_idx == 0);
      m_dead1  = ((s % RD1) == 0) && (s > 0);
      e_an1    = blank || m_dead1;
      e_seg1   = blank ? 7'h7F : 7'h40;
      e_fd1    = m_dead1;
      m_bnd = (m_pos == N * RD - 1);
      if (m_bnd) begin
        if (vv) begin
          for (int k = 0; k < N; k++) md[k] = value[4*k +: 4];
          mdp = dp; mpf = 0;
        end else if (mpf) begin
          for (int k = 0; k < N; k++) md[k] = mp[k];
          mdp = mpdp; mpf = 0;
        end
      end else if (vv) begin
        for (int k = 0; k < N; k++) mp[k] = value[4*k +: 4];
        mpdp = dp; mpf = 1;
      end
      s++;
    end
  end

  always @(negedge clk) begin
    chk("an", {12'b0, an_a}, {12'b0, e_an});
    chk("seg", {9'b0, seg_a}, {9'b0, e_seg_lz});
    chk("dp", {15'b0, dpl_a}, {15'b0, e_dpl});
    chk("frame_done", {15'b0, fd_a}, {15'b0, e_fd});
    chk("an_nolz", {12'b0, an_b}, {12'b0, e_an});
    chk("seg_nolz", {9'b0, seg_b}, {9'b0, e_seg_nl});
    chk("dp_nolz", {15'b0, dpl_b}, {15'b0, e_dpl});
    chk("frame_done_nolz", {15'b0, fd_b}, {15'b0, e_fd});
    chk("an_one", {15'b0, an_c}, {15'b0, e_an1});
    chk("seg_one", {9'b0, seg_c}, {9'b0, e_seg1});
    chk("dp_one", {15'b0, dpl_c}, 16'h1);
    chk("frame_done_one", {15'b0, fd_c}, {15'b0, e_fd1});
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #2;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #2;
    chk("rst_an", {12'b0, an_a}, 16'h000F);
    chk("rst_seg", {9'b0, seg_a}, 16'h007F);
    chk("rst_dp", {15'b0, dpl_a}, 16'h1);
    chk("rst_fd", {15'b0, fd_a}, 16'h0);
    rst_n = 1'b1;
    tick(1);  // edge 1
    chk("pu_an0", {12'b0, an_a}, 16'b1110);
    chk("pu_seg0", {9'b0, seg_a}, 16'h0040);
    tick(4);  // edge 5
    chk("pu_dead", {12'b0, an_a}, 16'b1111);
    tick(1);  // edge 6
    chk("pu_an1", {12'b0, an_a}, 16'b1101);
    chk("pu_seg1", {9'b0, seg_a}, 16'h007F);
    tick(11); // edge 17
    chk("pu_fd", {15'b0, fd_a}, 16'h1);
    chk("pu_fd_dead", {12'b0, an_a}, 16'b1111);

    tick(4);  // edge 21: strobe mid digit 1
    value = 16'h12AB; vv = 1'b1;
    tick(1);
    vv = 1'b0;
    tick(5);  // edge 27
    chk("tear_an2", {12'b0, an_a}, 16'b1011);
    chk("tear_old2", {9'b0, seg_a}, 16'h007F);
    tick(7);  // edge 34
    chk("upd_d0", {9'b0, seg_a}, 16'h0003);
    tick(4);
    chk("upd_d1", {9'b0, seg_a}, 16'h0008);
    tick(4);
    chk("upd_d2", {9'b0, seg_a}, 16'h0024);
    tick(4);  // edge 46
    chk("upd_d3", {9'b0, seg_a}, 16'h0079);

    tick(1);  // edge 47: strobe lands on the boundary edge
    value = 16'h0005; vv = 1'b1;
    tick(1);
    vv = 1'b0;
    tick(2);  // edge 50
    chk("sim_d0", {9'b0, seg_a}, 16'h0012);
    tick(4);
    chk("sim_d1", {9'b0, seg_a}, 16'h007F);

    tick(1);  // edge 55
    value = 16'h0100; dp = 4'b0100; vv = 1'b1;
    tick(1);
    vv = 1'b0;
    tick(10); // edge 66
    chk("lz_d0", {9'b0, seg_a}, 16'h0040);
    tick(4);
    chk("lz_d1", {9'b0, seg_a}, 16'h0040);
    tick(4);  // edge 74
    chk("lz_d2", {9'b0, seg_a}, 16'h0079);
    chk("lz_dp2", {15'b0, dpl_a}, 16'h0);
    tick(4);  // edge 78
    chk("lz_d3", {9'b0, seg_a}, 16'h007F);
    chk("nolz_d3", {9'b0, seg_b}, 16'h0040);
    chk("lz_dp3", {15'b0, dpl_a}, 16'h1);

    tick(1);  // edge 79
    blank = 1'b1;
    tick(2);  // edge 81
    chk("blk_fd", {15'b0, fd_a}, 16'h1);
    chk("blk_an", {12'b0, an_a}, 16'h000F);
    chk("blk_seg", {9'b0, seg_a}, 16'h007F);
    tick(8);  // edge 89
    blank = 1'b0;
    tick(2);  // edge 91, digit 2 lit
    chk("pre_rst_an", {12'b0, an_a}, 16'b1011);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_an", {12'b0, an_a}, 16'h000F);
    chk("mid_rst_seg", {9'b0, seg_a}, 16'h007F);
    chk("mid_rst_dp", {15'b0, dpl_a}, 16'h1);
    tick(1);
    rst_n = 1'b1;
    tick(1);
    chk("rst_an0", {12'b0, an_a}, 16'b1110);
    chk("rst_seg0", {9'b0, seg_a}, 16'h0040);
    tick(9);  // edge 10: cleared display shows dark digit 2
    chk("rst_an2", {12'b0, an_a}, 16'b1011);
    chk("rst_seg2", {9'b0, seg_a}, 16'h007F);
    tick(20);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
